// File: rtl/data_ram_ctrl.sv
// ============================================================================
//  Module   : data_ram_ctrl
//  Brief    : Byte-addressed big-endian data memory with programmable access
//             latency, stall request and registered completion pulse.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module data_ram_ctrl #(
  parameter int LATENCY = 2,
  parameter int DEPTH   = 256
) (
  input  logic        Clk,
  input  logic        Clr,
  input  logic        E,
  input  logic        RW,
  input  logic        Size,
  input  logic [7:0]  A,
  input  logic [31:0] DI,
  output logic [31:0] DO,
  output logic        Ready,
  output logic        Err,
  output logic        Stall
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] c_cnt_init = 4'(LATENCY - 1);

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic        r_rw;
  logic        r_size;
  logic [7:0]  r_a;
  logic [31:0] r_di;
  logic [7:0]  r_mem [DEPTH];

  logic        w_accept;
  logic        w_access;
  logic        w_misaligned;
  logic [7:0]  w_a0, w_a1, w_a2, w_a3;
  logic [31:0] w_rdata;

  assign w_accept     = (r_state == S_IDLE) && E;
  assign w_access     = (r_state == S_WAIT) && (r_cnt == 4'd0);
  assign w_misaligned = !r_size && (r_a[1:0] != 2'b00);

  // Word lanes only matter for aligned accesses, so the base is forced aligned.
  assign w_a0 = {r_a[7:2], 2'd0};
  assign w_a1 = {r_a[7:2], 2'd1};
  assign w_a2 = {r_a[7:2], 2'd2};
  assign w_a3 = {r_a[7:2], 2'd3};

  assign w_rdata = r_size ? {24'd0, r_mem[r_a]}
                          : {r_mem[w_a0], r_mem[w_a1], r_mem[w_a2], r_mem[w_a3]};

  always_ff @(posedge Clk) begin
    if (Clr) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    Stall  = 1'b0;
    case (r_state)
      S_IDLE: begin
        Stall = E;
        if (E) w_next = S_WAIT;
      end
      S_WAIT: begin
        Stall = 1'b1;
        if (r_cnt == 4'd0) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Clr) begin
      r_cnt  <= 4'd0;
      r_rw   <= 1'b0;
      r_size <= 1'b0;
      r_a    <= 8'd0;
      r_di   <= 32'd0;
      DO     <= 32'd0;
      Ready  <= 1'b0;
      Err    <= 1'b0;
    end else begin
      Ready <= 1'b0;
      Err   <= 1'b0;
      if (w_accept) begin
        r_rw   <= RW;
        r_size <= Size;
        r_a    <= A;
        r_di   <= DI;
        r_cnt  <= c_cnt_init;
      end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_access) begin
        Ready <= 1'b1;
        Err   <= w_misaligned;
        if (!r_rw) DO <= w_misaligned ? 32'd0 : w_rdata;
      end
    end
  end

  // Array contents survive Clr; only an access edge without reset may write.
  always_ff @(posedge Clk) begin
    if (!Clr && w_access && r_rw && !w_misaligned) begin
      if (r_size) begin
        r_mem[r_a] <= r_di[7:0];
      end else begin
        r_mem[w_a0] <= r_di[31:24];
        r_mem[w_a1] <= r_di[23:16];
        r_mem[w_a2] <= r_di[15:8];
        r_mem[w_a3] <= r_di[7:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_data_ram_ctrl.sv
// ============================================================================
//  Module   : tb_data_ram_ctrl
//  Brief    : Directed self-checking bench for data_ram_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_data_ram_ctrl;

  logic        clk;
  logic        Clr;
  logic        RW;
  logic        Size;
  logic [7:0]  A;
  logic [31:0] DI;
  logic        e2, e1, e15;
  logic [31:0] dout2, dout1, dout15;
  logic        rdy2, rdy1, rdy15;
  logic        err2, err1, err15;
  logic        stl2, stl1, stl15;

  int checks = 0;
  int errors = 0;

  data_ram_ctrl #(.LATENCY(2), .DEPTH(256)) dut (
    .Clk(clk), .Clr(Clr), .E(e2), .RW(RW), .Size(Size), .A(A), .DI(DI),
    .DO(dout2), .Ready(rdy2), .Err(err2), .Stall(stl2)
  );
  data_ram_ctrl #(.LATENCY(1), .DEPTH(256)) dut1 (
    .Clk(clk), .Clr(Clr), .E(e1), .RW(RW), .Size(Size), .A(A), .DI(DI),
    .DO(dout1), .Ready(rdy1), .Err(err1), .Stall(stl1)
  );
  data_ram_ctrl #(.LATENCY(15), .DEPTH(256)) dut15 (
    .Clk(clk), .Clr(Clr), .E(e15), .RW(RW), .Size(Size), .A(A), .DI(DI),
    .DO(dout15), .Ready(rdy15), .Err(err15), .Stall(stl15)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_e(input int w, input logic v);
    case (w)
      1:       e1  = v;
      15:      e15 = v;
      default: e2  = v;
    endcase
  endtask

  function automatic logic get_ready(input int w);
    case (w)
      1:       return rdy1;
      15:      return rdy15;
      default: return rdy2;
    endcase
  endfunction

  function automatic logic get_stall(input int w);
    case (w)
      1:       return stl1;
      15:      return stl15;
      default: return stl2;
    endcase
  endfunction

  function automatic logic get_err(input int w);
    case (w)
      1:       return err1;
      15:      return err15;
      default: return err2;
    endcase
  endfunction

  function automatic logic [31:0] get_do(input int w);
    case (w)
      1:       return dout1;
      15:      return dout15;
      default: return dout2;
    endcase
  endfunction

  // Issues one request (E high for one cycle) and measures the cycle index of
  // the Ready pulse, the number of stalled cycles, and DO/Err at Ready.
  task automatic run_access(input int w, input logic rw, input logic sz,
                            input logic [7:0] addr, input logic [31:0] d,
                            output int lat, output int stalls,
                            output logic [31:0] dout, output logic er);
    RW = rw; Size = sz; A = addr; DI = d;
    set_e(w, 1'b1);
    lat = -1; stalls = 0; dout = 32'd0; er = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (get_stall(w)) stalls++;
      if (get_ready(w)) begin
        lat = c; dout = get_do(w); er = get_err(w);
        break;
      end
      @(posedge clk); #1;
      if (c == 0) set_e(w, 1'b0);
    end
    set_e(w, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if ({stl2, rdy2, err2, dout2} !== 35'd0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: stall=%b ready=%b err=%b do=%h, need all 0",
                 c, stl2, rdy2, err2, dout2);
      end
    end
    e2 = 1'b1; #1;
    checks++;
    if (stl2 !== 1'b1) begin errors++; $display("FAIL stall_follows_e: got %b need 1", stl2); end
    e2 = 1'b0; #1;
    checks++;
    if (stl2 !== 1'b0) begin errors++; $display("FAIL stall_follows_e_low: got %b need 0", stl2); end
    @(posedge clk); #1;
  endtask

  task automatic test_word();
    int lat, st; logic [31:0] d; logic er;
    run_access(2, 1'b1, 1'b0, 8'h10, 32'hDEADBEEF, lat, st, d, er);
    checks++;
    if (lat !== 3 || st !== 3 || er !== 1'b0 || d !== 32'd0) begin
      errors++;
      $display("FAIL word_write: lat=%0d stalls=%0d err=%b do=%h, need 3 3 0 00000000", lat, st, er, d);
    end
    run_access(2, 1'b0, 1'b0, 8'h10, 32'h0, lat, st, d, er);
    checks++;
    if (lat !== 3 || st !== 3 || er !== 1'b0) begin
      errors++;
      $display("FAIL word_read_timing: lat=%0d stalls=%0d err=%b, need 3 3 0", lat, st, er);
    end
    checks++;
    if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL word_read_data: got %h need deadbeef", d); end
  endtask

  task automatic test_byte();
    int lat, st; logic [31:0] d; logic er;
    run_access(2, 1'b1, 1'b1, 8'h11, 32'h000000AA, lat, st, d, er);
    checks++;
    if (d !== 32'hDEADBEEF || lat !== 3) begin
      errors++;
      $display("FAIL byte_write_keeps_do: do=%h lat=%0d, need deadbeef 3", d, lat);
    end
    run_access(2, 1'b0, 1'b0, 8'h10, 32'h0, lat, st, d, er);
    checks++;
    if (d !== 32'hDEAABEEF) begin errors++; $display("FAIL byte_merge: got %h need deaabeef", d); end
    run_access(2, 1'b0, 1'b1, 8'h11, 32'h0, lat, st, d, er);
    checks++;
    if (d !== 32'h000000AA) begin errors++; $display("FAIL byte_read: got %h need 000000aa", d); end
  endtask

  task automatic test_misaligned();
    int lat, st; logic [31:0] d; logic er;
    run_access(2, 1'b1, 1'b0, 8'h13, 32'h12345678, lat, st, d, er);
    checks++;
    if (er !== 1'b1 || lat !== 3 || st !== 3) begin
      errors++;
      $display("FAIL misaligned_write: err=%b lat=%0d stalls=%0d, need 1 3 3", er, lat, st);
    end
    run_access(2, 1'b0, 1'b0, 8'h10, 32'h0, lat, st, d, er);
    checks++;
    if (d !== 32'hDEAABEEF || er !== 1'b0) begin
      errors++;
      $display("FAIL misaligned_no_write: do=%h err=%b, need deaabeef 0", d, er);
    end
    run_access(2, 1'b0, 1'b0, 8'h12, 32'h0, lat, st, d, er);
    checks++;
    if (d !== 32'd0 || er !== 1'b1 || lat !== 3) begin
      errors++;
      $display("FAIL misaligned_read: do=%h err=%b lat=%0d, need 00000000 1 3", d, er, lat);
    end
    run_access(2, 1'b0, 1'b1, 8'h13, 32'h0, lat, st, d, er);
    checks++;
    if (d !== 32'h000000EF || er !== 1'b0) begin
      errors++;
      $display("FAIL misaligned_byte13: do=%h err=%b, need 000000ef 0", d, er);
    end
  endtask

  task automatic test_top_byte();
    int lat, st; logic [31:0] d; logic er;
    run_access(2, 1'b1, 1'b1, 8'hFF, 32'h0000005A, lat, st, d, er);
    run_access(2, 1'b0, 1'b1, 8'hFF, 32'h0, lat, st, d, er);
    checks++;
    if (d !== 32'h0000005A || er !== 1'b0) begin
      errors++;
      $display("FAIL top_byte: do=%h err=%b, need 0000005a 0", d, er);
    end
  endtask

  task automatic test_clr_mid();
    int lat, st; logic [31:0] d; logic er; logic seen;
    run_access(2, 1'b1, 1'b0, 8'h20, 32'h11223344, lat, st, d, er);
    run_access(2, 1'b0, 1'b0, 8'h20, 32'h0, lat, st, d, er);
    checks++;
    if (d !== 32'h11223344) begin errors++; $display("FAIL clr_setup: got %h need 11223344", d); end
    RW = 1'b1; Size = 1'b0; A = 8'h20; DI = 32'hCAFEF00D; e2 = 1'b1;
    @(posedge clk); #1;
    e2 = 1'b0; Clr = 1'b1;
    @(posedge clk); #1;
    Clr = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rdy2) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL clr_no_ready: ready seen=%b need 0", seen); end
    checks++;
    if (dout2 !== 32'd0) begin errors++; $display("FAIL clr_do_reset: got %h need 00000000", dout2); end
    run_access(2, 1'b0, 1'b0, 8'h20, 32'h0, lat, st, d, er);
    checks++;
    if (d !== 32'h11223344) begin errors++; $display("FAIL clr_write_dropped: got %h need 11223344", d); end
    // Reset and request on the same edge: nothing may be latched.
    e2 = 1'b1; Clr = 1'b1;
    @(posedge clk); #1;
    e2 = 1'b0; Clr = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (stl2 || rdy2) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL clr_beats_e: activity=%b need 0", seen); end
  endtask

  task automatic test_latency();
    int lat, st; logic [31:0] d; logic er;
    run_access(1, 1'b1, 1'b0, 8'h40, 32'h01020304, lat, st, d, er);
    checks++;
    if (lat !== 2 || st !== 2) begin
      errors++;
      $display("FAIL lat1_write: lat=%0d stalls=%0d, need 2 2", lat, st);
    end
    run_access(1, 1'b0, 1'b0, 8'h40, 32'h0, lat, st, d, er);
    checks++;
    if (lat !== 2 || d !== 32'h01020304) begin
      errors++;
      $display("FAIL lat1_read: lat=%0d do=%h, need 2 01020304", lat, d);
    end
    run_access(15, 1'b1, 1'b0, 8'h40, 32'h0A0B0C0D, lat, st, d, er);
    run_access(15, 1'b0, 1'b0, 8'h40, 32'h0, lat, st, d, er);
    checks++;
    if (lat !== 16 || st !== 16 || d !== 32'h0A0B0C0D) begin
      errors++;
      $display("FAIL lat15_read: lat=%0d stalls=%0d do=%h, need 16 16 0a0b0c0d", lat, st, d);
    end
  endtask

  initial begin
    Clr = 1'b1; e2 = 1'b0; e1 = 1'b0; e15 = 1'b0;
    RW = 1'b0; Size = 1'b0; A = 8'd0; DI = 32'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    Clr = 1'b0;
    test_reset();
    test_word();
    test_byte();
    test_misaligned();
    test_top_byte();
    test_clr_mid();
    test_latency();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
